// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: sequencer states, instruction codes and status encodings.
package y86_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALT
    } state_t;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] ICMOVXX = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [1:0] SAOK = 2'd0;
    localparam logic [1:0] SHLT = 2'd1;
    localparam logic [1:0] SADR = 2'd2;
    localparam logic [1:0] SINS = 2'd3;

    // Instructions that touch data memory and therefore wait on mem_ready
    function automatic logic is_mem_icode(input logic [3:0] ic);
        return ic inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
    endfunction

endpackage

// File: rtl/y86_stage_sequencer_perf_counter.sv
// Busy-cycle and retired-instruction counters for the stage sequencer (used with SEQ_PERF_CNT_EN).
module seq_perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             busy,
    input  logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
            cycle_cnt   <= '0;
        end else begin
            if (busy)
                cycle_cnt <= cycle_cnt + 1'b1;
            if (retire)
                retired_cnt <= retired_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/y86_stage_sequencer.sv
// Sequential Y86-64 stage sequencer FSM with registered per-stage enables.
// Define SEQ_PERF_CNT_EN to add the retired_cnt/cycle_cnt performance counters.
module y86_stage_sequencer
    import y86_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] icode,
    input  logic       instr_valid,
    input  logic       imem_error,
    input  logic       dmem_error,
    input  logic       mem_ready,
    output logic       fetch_en,
    output logic       decode_en,
    output logic       execute_en,
    output logic       memory_en,
    output logic       writeback_en,
    output logic       pc_update_en,
    output logic       cc_update_en,
    output logic       mem_req,
    output logic [1:0] stat,
    output logic       busy,
    output logic       halted
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] cycle_cnt
`endif
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [1:0]        stat_d;
    logic [3:0]        icode_q;
    logic [WAIT_W-1:0] wait_q, wait_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stat    <= SAOK;
            icode_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            stat    <= stat_d;
            wait_q  <= wait_d;
            if (state_q == S_FETCH)
                icode_q <= icode;
        end
    end

    always_comb begin
        state_d = state_q;
        stat_d  = stat;
        wait_d  = '0;
        case (state_q)
            S_IDLE:
                if (start)
                    state_d = S_FETCH;
            S_FETCH: begin
                if (imem_error) begin
                    state_d = S_HALT;
                    stat_d  = SADR;
                end else if (!instr_valid) begin
                    state_d = S_HALT;
                    stat_d  = SINS;
                end else if (icode == IHALT) begin
                    state_d = S_HALT;
                    stat_d  = SHLT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_MEMORY;
            S_MEMORY: begin
                if (!is_mem_icode(icode_q)) begin
                    state_d = S_WRITEBACK;
                end else if (mem_ready) begin
                    state_d = dmem_error ? S_HALT : S_WRITEBACK;
                    stat_d  = dmem_error ? SADR : stat;
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    // This cycle is the last permitted wait without mem_ready
                    state_d = S_HALT;
                    stat_d  = SADR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD:     state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each flop is high exactly while in its state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_en     <= 1'b0;
            decode_en    <= 1'b0;
            execute_en   <= 1'b0;
            memory_en    <= 1'b0;
            writeback_en <= 1'b0;
            pc_update_en <= 1'b0;
            cc_update_en <= 1'b0;
            mem_req      <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
        end else begin
            fetch_en     <= (state_d == S_FETCH);
            decode_en    <= (state_d == S_DECODE);
            execute_en   <= (state_d == S_EXECUTE);
            memory_en    <= (state_d == S_MEMORY);
            writeback_en <= (state_d == S_WRITEBACK);
            pc_update_en <= (state_d == S_PCUPD);
            cc_update_en <= (state_d == S_EXECUTE) && (icode_q == IOPQ);
            mem_req      <= (state_d == S_MEMORY) && is_mem_icode(icode_q);
            busy         <= (state_d != S_IDLE) && (state_d != S_HALT);
            halted       <= (state_d == S_HALT);
        end
    end

`ifdef SEQ_PERF_CNT_EN
    seq_perf_counter #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk        (clk),
        .rst_n      (rst_n),
        .busy       (busy),
        .retire     (pc_update_en),
        .retired_cnt(retired_cnt),
        .cycle_cnt  (cycle_cnt)
    );
`endif

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// Directed self-checking bench for y86_stage_sequencer (counter checks only with SEQ_PERF_CNT_EN).
module tb_y86_stage_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] icode = 4'h0;
    logic       instr_valid = 1'b0;
    logic       imem_error = 1'b0;
    logic       dmem_error = 1'b0;
    logic       mem_ready = 1'b0;
    logic       fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_update_en;
    logic       cc_update_en, mem_req, busy, halted;
    logic [1:0] stat;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt, cycle_cnt;
`endif

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned lat, mreq, w;

    y86_stage_sequencer #(
        .CNT_W      (32),
        .MEM_TIMEOUT(15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .dmem_error  (dmem_error),
        .mem_ready   (mem_ready),
        .fetch_en    (fetch_en),
        .decode_en   (decode_en),
        .execute_en  (execute_en),
        .memory_en   (memory_en),
        .writeback_en(writeback_en),
        .pc_update_en(pc_update_en),
        .cc_update_en(cc_update_en),
        .mem_req     (mem_req),
        .stat        (stat),
        .busy        (busy),
        .halted      (halted)
`ifdef SEQ_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .cycle_cnt   (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] ens();
        return {fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_update_en};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // All status/enable outputs at their reset values
    task automatic chk_quiet(input string tag);
        chk({tag, "_ens"}, {26'd0, ens()}, 32'd0);
        chk({tag, "_misc"}, {28'd0, cc_update_en, mem_req, busy, halted}, 32'd0);
        chk({tag, "_stat"}, {30'd0, stat}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mem_ready = 1'b0;
        dmem_error = 1'b0;
        imem_error = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst_n = 1'b1;
        tick();

        // OPq: one cycle per stage, cc update in EXECUTE only
        start = 1'b1; icode = 4'h6; instr_valid = 1'b1;
        tick();
        start = 1'b0;
        chk("opq_fetch", {26'd0, ens()}, 32'b100000);
        chk("opq_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("opq_decode", {26'd0, ens()}, 32'b010000);
        tick();
        chk("opq_execute", {26'd0, ens()}, 32'b001000);
        chk("opq_cc_exe", {31'd0, cc_update_en}, 32'd1);
        tick();
        chk("opq_memory", {26'd0, ens()}, 32'b000100);
        chk("opq_cc_mem_req", {30'd0, cc_update_en, mem_req}, 32'd0);
        tick();
        chk("opq_writeback", {26'd0, ens()}, 32'b000010);
        tick();
        chk("opq_pcupd", {26'd0, ens()}, 32'b000001);
        icode = 4'h5;
        tick();
        chk("opq_refetch", {26'd0, ens()}, 32'b100000);
`ifdef SEQ_PERF_CNT_EN
        chk("opq_retired", retired_cnt, 32'd1);
`endif

        // MRMOVQ with three wait cycles before mem_ready
        lat = 0; mreq = 0; w = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (fetch_en || halted) break;
            if (mem_req) mreq++;
            if (memory_en) begin
                mem_ready = (w == 3);
                w++;
            end else begin
                mem_ready = 1'b0;
            end
        end
        mem_ready = 1'b0;
        chk("mrm_latency", lat, 32'd9);
        chk("mrm_memreq_cycles", mreq, 32'd4);
        chk("mrm_stat", {30'd0, stat}, 32'd0);
        chk("mrm_refetch", {31'd0, fetch_en}, 32'd1);

        // HALT instruction; later start pulses are ignored
        icode = 4'h0;
        tick();
        chk("hlt_stat", {30'd0, stat}, 32'd1);
        chk("hlt_halted_busy", {30'd0, halted, busy}, 32'b10);
        chk("hlt_ens", {26'd0, ens()}, 32'd0);
`ifdef SEQ_PERF_CNT_EN
        chk("hlt_cycles", cycle_cnt, 32'd16);
        chk("hlt_retired", retired_cnt, 32'd2);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("hlt_start_ignored", {28'd0, stat, halted, fetch_en}, 32'b0110);

        // RMMOVQ with mem_ready never arriving: timeout after 15 waits
        do_reset();
        chk_quiet("rst2");
        start = 1'b1; icode = 4'h4; instr_valid = 1'b1;
        tick();
        start = 1'b0;
        mreq = 0;
        for (int i = 0; i < 40; i++) begin
            if (halted) break;
            if (mem_req) mreq++;
            tick();
        end
        chk("tmo_memreq_cycles", mreq, 32'd15);
        chk("tmo_stat", {30'd0, stat}, 32'd2);
        chk("tmo_halt_req", {30'd0, halted, mem_req}, 32'b10);

        // CALL with mem_ready and dmem_error together
        do_reset();
        start = 1'b1; icode = 4'h8; instr_valid = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("dme_in_memory", {30'd0, memory_en, mem_req}, 32'b11);
        mem_ready = 1'b1; dmem_error = 1'b1;
        tick();
        mem_ready = 1'b0; dmem_error = 1'b0;
        chk("dme_stat", {29'd0, halted, stat}, 32'b110);

        // imem_error outranks an illegal instruction
        do_reset();
        start = 1'b1; icode = 4'h6; instr_valid = 1'b0; imem_error = 1'b1;
        tick();
        start = 1'b0;
        tick();
        imem_error = 1'b0;
        chk("adr_priority", {29'd0, halted, stat}, 32'b110);

        do_reset();
        start = 1'b1; icode = 4'h6; instr_valid = 1'b0;
        tick();
        start = 1'b0;
        tick();
        chk("ins_stat", {29'd0, halted, stat}, 32'b111);

        // Asynchronous reset in the middle of MEMORY, then a normal instruction
        do_reset();
        start = 1'b1; icode = 4'h5; instr_valid = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("arst_in_memory", {30'd0, memory_en, mem_req}, 32'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("arst");
`ifdef SEQ_PERF_CNT_EN
        chk("arst_counters", retired_cnt | cycle_cnt, 32'd0);
`endif
        #1;
        rst_n = 1'b1;
        tick();
        chk("arst_idle", {31'd0, busy}, 32'd0);
        start = 1'b1; icode = 4'h1;
        tick();
        start = 1'b0;
        chk("arst_fetch", {26'd0, ens()}, 32'b100000);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (fetch_en || halted) break;
        end
        chk("arst_nop_latency", lat, 32'd6);
        chk("arst_nop_stat", {29'd0, halted, stat}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
